// File: rtl/rsa_xcel_mont_pkg.sv
// Shared types and widths for the Montgomery multiplier slice.
package rsa_xcel_mont_pkg;
   localparam int MONT_WIDTH     = 32;
   localparam int MONT_ACC_WIDTH = 33;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      SUB  = 2'd2,
      DONE = 2'd3
   } mont_state_t;

   // Counter preload: number of CALC cycles minus one.
   function automatic logic [4:0] mont_last_step(input int nsteps);
      return 5'(MONT_WIDTH / nsteps - 1);
   endfunction
endpackage

// File: rtl/rsa_xcel_mont_AddReds.sv
// Combinational chain of p_nsteps radix-2 Montgomery add-reduce steps.
module rsa_xcel_mont_AddReds
   import rsa_xcel_mont_pkg::*;
#(
   parameter int p_nsteps = 4
) (
   input  logic [p_nsteps-1:0]       x_bits_i,
   input  logic [MONT_WIDTH-1:0]     y_i,
   input  logic [MONT_WIDTH-1:0]     n_i,
   input  logic [MONT_ACC_WIDTH-1:0] r_i,
   output logic [MONT_ACC_WIDTH-1:0] result_out_o
);
   logic [p_nsteps:0][MONT_ACC_WIDTH-1:0] r_stg;

   assign r_stg[0] = r_i;

   for (genvar i = 0; i < p_nsteps; i++) begin : g_stage
      // One extra bit of headroom: r + y + n < 4n for legal operands.
      logic [MONT_ACC_WIDTH:0] sum;
      logic [MONT_ACC_WIDTH:0] red;
      assign sum = {1'b0, r_stg[i]} + (x_bits_i[i] ? {2'b00, y_i} : '0);
      assign red = sum + (sum[0] ? {2'b00, n_i} : '0);
      assign r_stg[i+1] = red[MONT_ACC_WIDTH:1];
   end

   assign result_out_o = r_stg[p_nsteps];
endmodule

// File: rtl/rsa_xcel_mont_montmul.sv
// Sequential Montgomery multiplier: x*y*2^-32 mod n over val/rdy streams.
// Optional RSA_XCEL_MONT_ODD_CHECK_EN: even modulus returns 0 without computing.
module rsa_xcel_mont_montmul
   import rsa_xcel_mont_pkg::*;
#(
   parameter int p_nsteps = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  istream_val,
   output logic                  istream_rdy,
   input  logic [MONT_WIDTH-1:0] istream_x,
   input  logic [MONT_WIDTH-1:0] istream_y,
   input  logic [MONT_WIDTH-1:0] istream_n,
   output logic                  ostream_val,
   input  logic                  ostream_rdy,
   output logic [MONT_WIDTH-1:0] ostream_result
);
   mont_state_t               state_q, state_d;
   logic [MONT_WIDTH-1:0]     x_q, x_d;
   logic [MONT_WIDTH-1:0]     y_q, y_d;
   logic [MONT_WIDTH-1:0]     n_q, n_d;
   logic [MONT_ACC_WIDTH-1:0] r_q, r_d;
   logic [4:0]                cnt_q, cnt_d;
   logic [MONT_WIDTH-1:0]     result_q, result_d;

   logic [MONT_ACC_WIDTH-1:0] chain_out;
   logic [MONT_ACC_WIDTH-1:0] r_minus_n;

   rsa_xcel_mont_AddReds #(.p_nsteps(p_nsteps)) u_addreds (
      .x_bits_i     (x_q[p_nsteps-1:0]),
      .y_i          (y_q),
      .n_i          (n_q),
      .r_i          (r_q),
      .result_out_o (chain_out)
   );

   assign r_minus_n = r_q - {1'b0, n_q};

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      n_d      = n_q;
      r_d      = r_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      unique case (state_q)
         IDLE: begin
            if (istream_val) begin
               x_d     = istream_x;
               y_d     = istream_y;
               n_d     = istream_n;
               r_d     = '0;
               cnt_d   = mont_last_step(p_nsteps);
               state_d = CALC;
`ifdef RSA_XCEL_MONT_ODD_CHECK_EN
               if (!istream_n[0]) begin
                  result_d = '0;
                  state_d  = DONE;
               end
`endif
            end
         end
         CALC: begin
            r_d   = chain_out;
            x_d   = x_q >> p_nsteps;
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd0) begin
               cnt_d   = 5'd0;
               state_d = SUB;
            end
         end
         SUB: begin
            result_d = (r_q >= {1'b0, n_q}) ? r_minus_n[MONT_WIDTH-1:0]
                                             : r_q[MONT_WIDTH-1:0];
            state_d  = DONE;
         end
         DONE: begin
            if (ostream_rdy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         x_q      <= '0;
         y_q      <= '0;
         n_q      <= '0;
         r_q      <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         n_q      <= n_d;
         r_q      <= r_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   // Handshake outputs decode registered state only.
   assign istream_rdy    = (state_q == IDLE);
   assign ostream_val    = (state_q == DONE);
   assign ostream_result = result_q;
endmodule

// File: tb/tb_rsa_xcel_mont_montmul.sv
// Bench for rsa_xcel_mont_montmul: vector table + scoreboard on the p_nsteps=4 unit,
// plus one instance per legal p_nsteps for the latency sweep.
module tb_rsa_xcel_mont_montmul;
   localparam int NI   = 6;
   localparam int MAIN = 2;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NI-1:0]        ival;
   logic [31:0]          ix, iy, in_;
   logic                 ordy;
   logic [NI-1:0]        irdy, oval;
   logic [NI-1:0][31:0]  ores;

   int checks   = 0;
   int failures = 0;

   // bit 32 set = result is don't-care
   logic [32:0] sbq[$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      rsa_xcel_mont_montmul #(.p_nsteps(1 << g)) u_dut (
         .clk            (clk),
         .reset          (reset),
         .istream_val    (ival[g]),
         .istream_rdy    (irdy[g]),
         .istream_x      (ix),
         .istream_y      (iy),
         .istream_n      (in_),
         .ostream_val    (oval[g]),
         .ostream_rdy    (ordy),
         .ostream_result (ores[g])
      );
   end

   typedef struct {
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] n;
      logic [31:0] exp;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Independent reference: x*y*(2^-1)^32 mod n using 64-bit modular arithmetic.
   function automatic logic [31:0] ref_mont(input logic [31:0] x, input logic [31:0] y,
                                            input logic [31:0] n);
      logic [63:0] h, rinv, p;
      h    = ({32'd0, n} + 64'd1) >> 1;
      rinv = 64'd1;
      for (int k = 0; k < 32; k++) rinv = (rinv * h) % {32'd0, n};
      p = ({32'd0, x} * {32'd0, y}) % {32'd0, n};
      return 32'((p * rinv) % {32'd0, n});
   endfunction

   // Scoreboard for the main unit: pop on every output handshake.
   always @(negedge clk) begin
      if (!reset && oval[MAIN] && ordy) begin
         if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output: got %0h expected none", ores[MAIN]);
         end else begin
            logic [32:0] e;
            e = sbq.pop_front();
            if (!e[32]) check("sb_result", ores[MAIN], e[31:0]);
         end
      end
   end

   // Drive one request into the main unit; lat = edges after the accept edge until ostream_val.
   task automatic send_main(input logic [31:0] x, input logic [31:0] y, input logic [31:0] n,
                            input logic [32:0] expq, output int wait_cyc, output int lat);
      int w, c;
      w = 0;
      while (!irdy[MAIN] && w < 200) begin
         @(posedge clk); #1; w++;
      end
      if (w == 200) check("rdy_timeout", 32'd0, 32'd1);
      wait_cyc = w;
      ix = x; iy = y; in_ = n;
      ival[MAIN] = 1'b1;
      @(posedge clk); #1;
      ival[MAIN] = 1'b0;
      sbq.push_back(expq);
      c = 0;
      while (!oval[MAIN] && c < 200) begin
         @(posedge clk); #1; c++;
      end
      if (c == 200) check("val_timeout", 32'd0, 32'd1);
      lat = c;
   endtask

   initial begin
      vec_t vt[5];
      int   w, lat, c;
      int   seen[NI], lat_i[NI];
      logic [31:0] rx, ry, rn, held;

      vt[0] = '{32'd5,         32'd7,         32'd13,        32'd1};
      vt[1] = '{32'd12,        32'd12,        32'd13,        32'd3};
      vt[2] = '{32'd0,         32'd7,         32'd13,        32'd0};
      vt[3] = '{32'd1,         32'd1,         32'd13,        32'd3};
      vt[4] = '{32'hFFFFFFFE,  32'hFFFFFFFE,  32'hFFFFFFFF,  32'd1};

      reset = 1'b1; ival = '0; ix = '0; iy = '0; in_ = '0; ordy = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      check("reset_irdy",   32'(irdy[MAIN]), 32'd1);
      check("reset_oval",   32'(oval[MAIN]), 32'd0);
      check("reset_result", ores[MAIN],      32'd0);

      // Table vectors, result via scoreboard, latency checked here.
      for (int i = 0; i < 5; i++) begin
         send_main(vt[i].x, vt[i].y, vt[i].n, {1'b0, vt[i].exp}, w, lat);
         check($sformatf("latency_vec%0d", i), 32'(lat), 32'd9);
      end

      // Random legal operands against the reference model.
      for (int i = 0; i < 4; i++) begin
         rn = $urandom() | 32'h8000_0001;
         rx = $urandom() % rn;
         ry = $urandom() % rn;
         send_main(rx, ry, rn, {1'b0, ref_mont(rx, ry, rn)}, w, lat);
         check("latency_rand", 32'(lat), 32'd9);
      end

      // Backpressure: result and handshake must hold while the consumer stalls.
      @(posedge clk); #1;
      ordy = 1'b0;
      send_main(32'd12, 32'd12, 32'd13, {1'b0, 32'd3}, w, lat);
      held = ores[MAIN];
      check("bp_first_result", held, 32'd3);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check("bp_result_stable", ores[MAIN], held);
         check("bp_irdy_low", 32'(irdy[MAIN]), 32'd0);
         check("bp_oval_high", 32'(oval[MAIN]), 32'd1);
      end
      ordy = 1'b1;
      @(posedge clk); #1;
      send_main(32'd1, 32'd1, 32'd13, {1'b0, 32'd3}, w, lat);
      check("bp_next_accept_wait", 32'(w), 32'd0);
      check("bp_next_latency", 32'(lat), 32'd9);

      // Reset during the third CALC cycle drops the request.
      @(posedge clk); #1;
      ix = 32'd5; iy = 32'd7; in_ = 32'd13;
      ival[MAIN] = 1'b1;
      @(posedge clk); #1;
      ival[MAIN] = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("midreset_irdy", 32'(irdy[MAIN]), 32'd1);
      c = 0;
      for (int k = 0; k < 15; k++) begin
         if (oval[MAIN]) c++;
         @(posedge clk); #1;
      end
      check("midreset_no_output", 32'(c), 32'd0);
      send_main(32'd5, 32'd7, 32'd13, {1'b0, 32'd1}, w, lat);
      check("postreset_latency", 32'(lat), 32'd9);

      // Even modulus: shortcut to DONE only when the check is built in.
      @(posedge clk); #1;
`ifdef RSA_XCEL_MONT_ODD_CHECK_EN
      send_main(32'd5, 32'd7, 32'd12, {1'b0, 32'd0}, w, lat);
      check("even_n_latency", 32'(lat), 32'd0);
`else
      send_main(32'd5, 32'd7, 32'd12, {1'b1, 32'd0}, w, lat);
      check("even_n_latency", 32'(lat), 32'd9);
`endif

      // Latency sweep over every legal p_nsteps, all units started together.
      @(posedge clk); #1;
      for (int i = 0; i < NI; i++) begin
         seen[i] = 0; lat_i[i] = 0;
      end
      ix = 32'hFFFFFFFE; iy = 32'hFFFFFFFE; in_ = 32'hFFFFFFFF;
      ival = '1;
      @(posedge clk); #1;
      ival = '0;
      sbq.push_back({1'b0, 32'd1});
      for (int cc = 0; cc <= 40; cc++) begin
         for (int i = 0; i < NI; i++) begin
            if (oval[i] && !seen[i]) begin
               seen[i]  = 1;
               lat_i[i] = cc;
               check($sformatf("sweep_result_p%0d", 1 << i), ores[i], 32'd1);
            end
         end
         @(posedge clk); #1;
      end
      for (int i = 0; i < NI; i++) begin
         check($sformatf("sweep_seen_p%0d", 1 << i), 32'(seen[i]), 32'd1);
         check($sformatf("sweep_latency_p%0d", 1 << i), 32'(lat_i[i]), 32'(32 / (1 << i) + 1));
      end

      repeat (3) @(posedge clk);
      #1 check("scoreboard_drained", 32'(sbq.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
